// File: rtl/yoda_crypto_pkg.sv
// Shared types for the byte-stream crypto blocks: byte type, counter reset value
// and the decrypter FSM state encoding.
package yoda_crypto_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t COUNTER_RESET = 8'h00;

  typedef enum logic {
    IDLE,
    RUN
  } dec_state_e;

endpackage

// File: rtl/byte_decrypter.sv
// Combinational keystream XOR: plain = cipher ^ (counter ^ key).
module byte_decrypter
  import yoda_crypto_pkg::*;
(
  input  byte_t cipher_i,
  input  byte_t key_i,
  input  byte_t counter_i,
  output byte_t plain_o
);

  assign plain_o = cipher_i ^ (counter_i ^ key_i);

endmodule

// File: rtl/stream_decrypter.sv
// Registered, flow-controlled counter-mode byte decrypter (receive side).
// Optional STREAM_DECRYPTER_STATS_EN adds a saturating output handshake counter.
module stream_decrypter
  import yoda_crypto_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_load,
  input  logic [7:0]  key_in,
  input  logic [7:0]  seed_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_sof,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_sof
`ifdef STREAM_DECRYPTER_STATS_EN
  ,
  output logic [15:0] byte_count
`endif
);

  dec_state_e state_q, state_d;
  byte_t      key_q, seed_q, cnt_q, out_data_q;
  byte_t      cnt_sel, plain;
  logic       out_valid_q, out_sof_q, accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (key_load) begin
      state_d = RUN;
    end
  end

  // Ready looks only at the output stage, so a drain and a new accept can share a cycle.
  assign in_ready = (state_q == RUN) && !key_load && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign cnt_sel  = in_sof ? seed_q : cnt_q;

  byte_decrypter u_byte_decrypter (
    .cipher_i  (in_data),
    .key_i     (key_q),
    .counter_i (cnt_sel),
    .plain_o   (plain)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q  <= 8'h00;
      seed_q <= 8'h00;
      cnt_q  <= COUNTER_RESET;
    end else if (key_load) begin
      key_q  <= key_in;
      seed_q <= seed_in;
      cnt_q  <= seed_in;
    end else if (accept) begin
      cnt_q <= cnt_sel + 8'd1;
    end
  end

  // A pending byte survives key_load; it is only replaced by a new accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_sof_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= plain;
      out_sof_q   <= in_sof;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;

`ifdef STREAM_DECRYPTER_STATS_EN
  logic [15:0] byte_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_count_q <= 16'h0000;
    end else if (key_load) begin
      byte_count_q <= 16'h0000;
    end else if (out_valid_q && out_ready && (byte_count_q != 16'hFFFF)) begin
      byte_count_q <= byte_count_q + 16'd1;
    end
  end

  assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_stream_decrypter.sv
// Self-checking bench for stream_decrypter: a behavioural model checked every
// cycle plus directed streams with hand-computed plaintext.
module tb_stream_decrypter;
  import yoda_crypto_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  key_load = 1'b0;
  byte_t key_in = 8'h00;
  byte_t seed_in = 8'h00;
  logic  in_valid = 1'b0;
  logic  in_ready;
  byte_t in_data = 8'h00;
  logic  in_sof = 1'b0;
  logic  out_valid;
  logic  out_ready = 1'b1;
  byte_t out_data;
  logic  out_sof;
`ifdef STREAM_DECRYPTER_STATS_EN
  logic [15:0] byte_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  byte_t gotData[$];
  logic  gotSof[$];

  always #5 clk = ~clk;

  stream_decrypter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key_in    (key_in),
    .seed_in   (seed_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof)
`ifdef STREAM_DECRYPTER_STATS_EN
    ,
    .byte_count(byte_count)
`endif
  );

  // Behavioural model: key/seed/running counter plus the single pending output byte.
  byte_t mKey, mSeed, mCnt, mData;
  logic  mLoaded, mValid, mSof;
  logic  mReady, mAccept;
  byte_t mCounter;

  assign mReady   = mLoaded && !key_load && (!mValid || out_ready);
  assign mAccept  = in_valid && mReady;
  assign mCounter = in_sof ? mSeed : mCnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mKey <= 8'h00; mSeed <= 8'h00; mCnt <= 8'h00;
      mLoaded <= 1'b0; mValid <= 1'b0; mData <= 8'h00; mSof <= 1'b0;
    end else begin
      if (key_load) begin
        mKey <= key_in; mSeed <= seed_in; mCnt <= seed_in; mLoaded <= 1'b1;
      end else if (mAccept) begin
        mCnt <= mCounter + 8'd1;
      end
      if (mAccept) begin
        mValid <= 1'b1;
        mData  <= in_data ^ mCounter ^ mKey;
        mSof   <= in_sof;
      end else if (mValid && out_ready) begin
        mValid <= 1'b0;
      end
    end
  end

  task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare and capture of delivered bytes
  always @(negedge clk) begin
    compare("in_ready", {15'd0, in_ready}, {15'd0, mReady});
    compare("out_valid", {15'd0, out_valid}, {15'd0, mValid});
    if (mValid) begin
      compare("out_data", {8'd0, out_data}, {8'd0, mData});
      compare("out_sof", {15'd0, out_sof}, {15'd0, mSof});
    end
    if (rst_n && out_valid && out_ready) begin
      gotData.push_back(out_data);
      gotSof.push_back(out_sof);
    end
  end

  task automatic applyStimulus(input logic sof, input byte_t data);
    int  waitCycles;
    bit  done;
    waitCycles = 0;
    done = 1'b0;
    in_valid = 1'b1; in_sof = sof; in_data = data;
    while (!done && waitCycles < 20) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
      waitCycles++;
    end
    in_valid = 1'b0; in_sof = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: byte 0x%0h not accepted in 20 cycles", data);
    end
  endtask

  task automatic keyLoad(input byte_t key, input byte_t seed);
    key_load = 1'b1; key_in = key; seed_in = seed;
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input byte_t expData, input logic expSof);
    vectors++;
    if (gotData.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s: no byte delivered, expected 0x%0h", name, expData);
    end else begin
      byte_t d;
      logic  s;
      d = gotData.pop_front();
      s = gotSof.pop_front();
      if (d !== expData || s !== expSof) begin
        miscompares++;
        $display("[TB] FAIL %s: got data 0x%0h sof %0b expected data 0x%0h sof %0b",
                 name, d, s, expData, expSof);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    @(negedge clk);
    compare("reset_out_data", {8'd0, out_data}, 16'h0000);
    compare("reset_out_sof", {15'd0, out_sof}, 16'h0000);
    compare("reset_in_ready", {15'd0, in_ready}, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // No key loaded: nothing may be accepted
    in_valid = 1'b1; in_data = 8'h33;
    idle(3);
    in_valid = 1'b0;
    compare("idle_no_output", gotData.size(), 16'd0);

    // Key and counter basic
    keyLoad(8'h5A, 8'h00);
    applyStimulus(1'b1, 8'h5A);
    applyStimulus(1'b0, 8'h5B);
    applyStimulus(1'b0, 8'h58);
    idle(3);
    checkOutput("basic0", 8'h00, 1'b1);
    checkOutput("basic1", 8'h00, 1'b0);
    checkOutput("basic2", 8'h00, 1'b0);

    // Counter wrap 0xFF -> 0x00
    keyLoad(8'h00, 8'hFF);
    applyStimulus(1'b1, 8'hAA);
    applyStimulus(1'b0, 8'hAA);
    idle(3);
    checkOutput("wrap0", 8'h55, 1'b1);
    checkOutput("wrap1", 8'hAA, 1'b0);

    // Backpressure: hold out_ready low for 3 cycles after the first output
    keyLoad(8'h00, 8'h10);
    out_ready = 1'b0;
    applyStimulus(1'b1, 8'h10);
    fork
      applyStimulus(1'b0, 8'h11);
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare("stall_in_ready", {15'd0, in_ready}, 16'h0000);
        compare("stall_out_data", {8'd0, out_data}, 16'h0000);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(3);
    checkOutput("bp0", 8'h00, 1'b1);
    checkOutput("bp1", 8'h00, 1'b0);

    // Mid-stream resync via sof
    keyLoad(8'h00, 8'h10);
    applyStimulus(1'b1, 8'h10);
    applyStimulus(1'b0, 8'h11);
    applyStimulus(1'b0, 8'h12);
    applyStimulus(1'b1, 8'h10);
    applyStimulus(1'b0, 8'h11);
    idle(3);
    checkOutput("resync0", 8'h00, 1'b1);
    checkOutput("resync1", 8'h00, 1'b0);
    checkOutput("resync2", 8'h00, 1'b0);
    checkOutput("resync3", 8'h00, 1'b1);
    checkOutput("resync4", 8'h00, 1'b0);

    // Key reload with a pending byte (counter is 0x12 here: 0x20^0x12 = 0x32)
    out_ready = 1'b0;
    applyStimulus(1'b0, 8'h20);
    keyLoad(8'hFF, 8'h00);
    out_ready = 1'b1;
    idle(2);
    checkOutput("pending", 8'h32, 1'b0);
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b0, 8'hFE);
    idle(3);
    checkOutput("reload0", 8'h00, 1'b1);
    checkOutput("reload1", 8'h00, 1'b0);

    // Asynchronous reset while a byte is pending
    out_ready = 1'b0;
    applyStimulus(1'b0, 8'h55);
    #2 rst_n = 1'b0;
    #1;
    compare("rst_out_valid", {15'd0, out_valid}, 16'h0000);
    compare("rst_in_ready", {15'd0, in_ready}, 16'h0000);
    compare("rst_out_data", {8'd0, out_data}, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h44;
    idle(3);
    in_valid = 1'b0;
    compare("rst_discard", gotData.size(), 16'd0);
    keyLoad(8'h0F, 8'h00);
    applyStimulus(1'b1, 8'h0F);
    idle(3);
    checkOutput("post_reset", 8'h00, 1'b1);
    compare("leftover", gotData.size(), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_decrypter.md
# stream_decrypter

Receive-side counterpart of the byte encrypter: a registered, flow-controlled byte-stream decrypter. It recovers plaintext as `plain = cipher ^ (counter ^ key)` and keeps its own 8-bit counter in lock-step with the transmit side. It sits between the link receiver and the payload consumer, with valid/ready handshakes on both sides. Key and counter seed are loaded at run time.

## Interface
- No parameters; all widths are fixed at 8 bits.
- `clk` input 1: single clock. All logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `key_load` input 1: single-cycle pulse that latches `key_in` and `seed_in`.
- `key_in` input 8: key value.
- `seed_in` input 8: counter value applied to the first byte of every frame.
- `in_valid` input 1: a ciphertext byte is present.
- `in_ready` output 1: the block accepts a byte this cycle.
- `in_data` input 8: ciphertext byte.
- `in_sof` input 1: qualifies `in_data` as the first byte of a frame.
- `out_valid` output 1: a plaintext byte is present.
- `out_ready` input 1: the consumer accepts the byte.
- `out_data` output 8: plaintext byte.
- `out_sof` output 1: `in_sof` carried alongside the byte.

## Operation
- FSM has two states: `IDLE` (no key loaded) and `RUN`.
  - Reset puts the FSM in `IDLE`.
  - `key_load` moves `IDLE` to `RUN`.
  - `key_load` in `RUN` stays in `RUN` and reloads key, seed and counter.
- Registers: `key_q`, `seed_q`, `cnt_q` (8 bits each), and an output stage (`out_data`, `out_sof`, `out_valid`).
- `in_ready = (state==RUN) && !key_load && (!out_valid || out_ready)`.
  - This allows full throughput with one output register.
  - `in_ready` never depends on `in_valid`.
- A byte is accepted when `in_valid && in_ready`.
  - Counter used for the byte: `c = in_sof ? seed_q : cnt_q`.
  - Output stage loads `in_data ^ (c ^ key_q)`.
  - `cnt_q` becomes `c + 1` modulo 256 (0xFF wraps to 0x00).
- `cnt_q` does not move on cycles without an accepted byte, including backpressure stalls.
- On `key_load`:
  - `key_q <= key_in`, `seed_q <= seed_in`, `cnt_q <= seed_in`.
  - No byte is accepted that cycle.
  - A byte already held in the output stage is still delivered unchanged.
- When `out_valid && out_ready` with no new accept, `out_valid` clears next cycle.
- When accept and drain happen in the same cycle, the output stage is overwritten with the new byte and `out_valid` stays 1.
- Reset values:
  - `out_valid=0`, `out_data=0x00`, `out_sof=0`, `in_ready=0`.
  - `key_q=seed_q=cnt_q=0x00`, state `IDLE`.
- Reset asserted mid-stream discards the pending output byte. Key loss is intentional: a fresh `key_load` is required.

## Timing
- Latency is 1 cycle: a byte accepted at edge N drives `out_valid=1` / `out_data` after edge N.
- Throughput is 1 byte per cycle while `out_ready=1`.
- `key_load` at edge N: `in_ready` is low during that cycle. Bytes accepted at edge N+1 and later use the new key and counter.
- While `out_valid && !out_ready`, `out_data` and `out_sof` are held stable.

## Configuration
- Macro: `STREAM_DECRYPTER_STATS_EN`.
- Defined: adds output `byte_count [15:0]`.
  - Increments on every output handshake, saturating at 0xFFFF.
  - Cleared by reset and by `key_load`.
- Undefined: port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `yoda_crypto_pkg`: `byte_t` (`logic [7:0]`), `COUNTER_RESET = 8'h00`, and the FSM state enum `dec_state_e`.
- Sub-module `byte_decrypter`: combinational `(cipher, key, counter) -> plain`, instantiated once for the datapath.

## Test plan
- Key and counter basic:
  - Stimulus: `key_load` key=0x5A seed=0x00, then bytes 0x5A(sof), 0x5B, 0x58 with `out_ready=1`.
  - Response: outputs 0x00, 0x00, 0x00 on consecutive cycles, `out_sof` on the first byte.
- Wrap-around:
  - Stimulus: key=0x00 seed=0xFF, bytes 0xAA(sof), 0xAA.
  - Response: outputs 0x55, 0xAA (counter 0xFF then 0x00).
- Backpressure:
  - Stimulus: key=0x00 seed=0x10, bytes 0x10(sof), 0x11; hold `out_ready=0` for 3 cycles after the first output.
  - Response: 0x00 held for 3 cycles with `in_ready=0`, then 0x00 for the second byte; counter unchanged during the stall.
- Mid-stream resync:
  - Stimulus: key=0x00 seed=0x10, send 3 bytes, then 0x10 with sof.
  - Response: that byte outputs 0x00; the next byte 0x11 outputs 0x00.
- Key reload with pending output:
  - Stimulus: `key_load` (key=0xFF seed=0x00) while `out_valid=1` and `out_ready=0`.
  - Response: pending byte delivered unchanged, `in_ready=0` that cycle; next byte 0xFF(sof) outputs 0x00.
- Reset mid-stream:
  - Stimulus: assert `rst_n=0` asynchronously while `out_valid=1`.
  - Response: `out_valid`, `in_ready` and `out_data` go to 0 immediately; bytes are not accepted until `key_load`.
